// File: rtl/en_seq_pkg.sv
// Shared types and default sizing for the enable-stage sequencer.
package en_seq_pkg;

    localparam int unsigned NUM_STAGES_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 255;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN,
        ST_FAULT
    } state_e;

endpackage

// File: rtl/seq_timer.sv
// Per-stage ack wait counter: clear has priority, saturates at TIMEOUT-1 and flags expiry.
module seq_timer
    import en_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          expired;

    assign expired   = (cnt_q == CW'(TIMEOUT - 1));
    assign expired_o = expired;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/en_seq_ctrl.sv
// Sequences NUM_STAGES enables up in ascending and down in descending order,
// waiting for each stage's delayed ack and faulting on timeout or loss.
module en_seq_ctrl
    import en_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic                          req_i,
    input  logic [NUM_STAGES-1:0]         stage_ack_i,
    output logic [NUM_STAGES-1:0]         stage_en_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [$clog2(NUM_STAGES)-1:0] err_stage_o
);

    localparam int unsigned IW = $clog2(NUM_STAGES);

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] en_q, en_d;
    logic [IW-1:0]         err_stage_q, err_stage_d;

    logic                  tmr_clr_c;
    logic                  tmr_en_c;
    logic                  tmr_expired;
    logic                  ack_cur;
    logic                  lost_any;
    logic [IW-1:0]         lost_idx;

    seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .clr_i     (tmr_clr_c),
        .en_i      (tmr_en_c),
        .expired_o (tmr_expired)
    );

    assign ack_cur  = stage_ack_i[idx_q];
    assign lost_any = ~&stage_ack_i;

    // Lowest-index stage whose ack dropped; descending scan lets the lowest win.
    always_comb begin
        lost_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!stage_ack_i[i]) begin
                lost_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        en_d        = en_q;
        err_stage_d = err_stage_q;
        tmr_clr_c   = 1'b1;
        tmr_en_c    = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                if (req_i) begin
                    state_d = ST_RAMP_UP;
                    idx_d   = '0;
                    en_d    = NUM_STAGES'(1);
                end
            end

            ST_RAMP_UP: begin
                if (!req_i) begin
                    state_d     = ST_RAMP_DOWN;
                    en_d[idx_q] = 1'b0;
                end else if (ack_cur) begin
                    if (idx_q == IW'(NUM_STAGES - 1)) begin
                        state_d = ST_ON;
                    end else begin
                        idx_d       = idx_q + IW'(1);
                        en_d[idx_d] = 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d     = ST_FAULT;
                    err_stage_d = idx_q;
                    en_d        = '0;
                end else begin
                    tmr_clr_c = 1'b0;
                    tmr_en_c  = 1'b1;
                end
            end

            ST_ON: begin
                if (!req_i) begin
                    state_d                = ST_RAMP_DOWN;
                    idx_d                  = IW'(NUM_STAGES - 1);
                    en_d[NUM_STAGES - 1]   = 1'b0;
                end else if (lost_any) begin
                    state_d     = ST_FAULT;
                    err_stage_d = lost_idx;
                    en_d        = '0;
                end
            end

            ST_RAMP_DOWN: begin
                // A renewed request resumes at the current stage; lower stages stay on.
                if (req_i) begin
                    state_d     = ST_RAMP_UP;
                    en_d[idx_q] = 1'b1;
                end else if (!ack_cur) begin
                    if (idx_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        idx_d       = idx_q - IW'(1);
                        en_d[idx_d] = 1'b0;
                    end
                end else if (tmr_expired) begin
                    state_d     = ST_FAULT;
                    err_stage_d = idx_q;
                    en_d        = '0;
                end else begin
                    tmr_clr_c = 1'b0;
                    tmr_en_c  = 1'b1;
                end
            end

            ST_FAULT: begin
                en_d = '0;
                if (!req_i && !(|stage_ack_i)) begin
                    state_d     = ST_OFF;
                    idx_d       = '0;
                    err_stage_d = '0;
                end
            end

            default: begin
                state_d     = ST_OFF;
                idx_d       = '0;
                en_d        = '0;
                err_stage_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= ST_OFF;
            idx_q       <= '0;
            en_q        <= '0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            en_q        <= en_d;
            err_stage_q <= err_stage_d;
        end
    end

    assign stage_en_o  = en_q;
    assign busy_o      = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign done_o      = (state_q == ST_ON);
    assign err_o       = (state_q == ST_FAULT);
    assign err_stage_o = err_stage_q;

endmodule
